// File: rtl/gt_common_ctrl.sv
// GTP common-block controller: per-PLL power/reset/lock sequencing and a
// round-robin arbiter sharing the single common DRP port between two requesters.
module gt_common_ctrl #(
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_FILTER  = 8,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int DRP_TIMEOUT  = 64
) (
  input  logic             DRP_CLK,
  input  logic             RST,
  input  logic [1:0]       PLL_EN,
  input  logic [1:0]       PLL_RST_REQ,
  input  logic [1:0]       PLL_LOCK,
  input  logic [1:0]       PLL_REFCLKLOST,
  output logic [1:0]       PLL_PD,
  output logic [1:0]       PLL_RESET,
  output logic [1:0]       PLL_READY,
  output logic [1:0]       PLL_FAIL,
  input  logic [1:0]       REQ_EN,
  input  logic [1:0]       REQ_WE,
  input  logic [1:0][7:0]  REQ_ADDR,
  input  logic [1:0][15:0] REQ_DI,
  output logic [1:0]       REQ_RDY,
  output logic [1:0]       REQ_ERR,
  output logic [15:0]      REQ_DO,
  output logic [7:0]       DRP_ADDR,
  output logic             DRP_EN,
  output logic [15:0]      DRP_DI,
  output logic             DRP_WE,
  input  logic [15:0]      DRP_DO,
  input  logic             DRP_RDY
);

  localparam int PCNT_MAX = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_W    = $clog2(PCNT_MAX + 1);
  localparam int FLT_W    = $clog2(LOCK_FILTER + 1);
  localparam int TO_W     = $clog2(DRP_TIMEOUT + 1);

  typedef enum logic [2:0] {P_OFF, P_RESET, P_WAIT, P_READY, P_FAIL} pll_st_e;
  typedef enum logic [1:0] {A_IDLE, A_ISSUE, A_WAIT, A_DONE} arb_st_e;

  logic [1:0] lock_m_q, lock_s_q, refl_m_q, refl_s_q;

  pll_st_e            pst_q  [2];
  pll_st_e            pst_d  [2];
  logic [CNT_W-1:0]   pcnt_q [2];
  logic [CNT_W-1:0]   pcnt_d [2];
  logic [FLT_W-1:0]   filt_q [2];
  logic [FLT_W-1:0]   filt_d [2];
  logic [1:0] pd_q, pd_d, prst_q, prst_d, prdy_q, prdy_d, pfail_q, pfail_d;

  arb_st_e           ast_q, ast_d;
  logic              gnt_q, gnt_d, rr_q, rr_d, g_sel;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic [7:0]        addr_q, addr_d;
  logic [15:0]       di_q, di_d, rdo_q, rdo_d;
  logic              we_q, we_d, en_q, en_d;
  logic [1:0]        rdy_q, rdy_d, err_q, err_d;

  // Lock and refclk-lost are asynchronous to DRP_CLK
  always_ff @(posedge DRP_CLK or posedge RST) begin
    if (RST) begin
      lock_m_q <= '0;
      lock_s_q <= '0;
      refl_m_q <= '0;
      refl_s_q <= '0;
    end else begin
      lock_m_q <= PLL_LOCK;
      lock_s_q <= lock_m_q;
      refl_m_q <= PLL_REFCLKLOST;
      refl_s_q <= refl_m_q;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      pst_d[i]  = pst_q[i];
      pcnt_d[i] = pcnt_q[i];
      filt_d[i] = filt_q[i];
      if (!PLL_EN[i]) begin
        pst_d[i]  = P_OFF;
        pcnt_d[i] = '0;
        filt_d[i] = '0;
      end else if (PLL_RST_REQ[i] && (pst_q[i] != P_OFF)) begin
        pst_d[i]  = P_RESET;
        pcnt_d[i] = '0;
        filt_d[i] = '0;
      end else begin
        case (pst_q[i])
          P_OFF: begin
            pst_d[i]  = P_RESET;
            pcnt_d[i] = '0;
            filt_d[i] = '0;
          end
          P_RESET: begin
            if (pcnt_q[i] == CNT_W'(RESET_CYCLES - 1)) begin
              pst_d[i]  = P_WAIT;
              pcnt_d[i] = '0;
              filt_d[i] = '0;
            end else begin
              pcnt_d[i] = pcnt_q[i] + CNT_W'(1);
            end
          end
          P_WAIT: begin
            pcnt_d[i] = pcnt_q[i] + CNT_W'(1);
            filt_d[i] = lock_s_q[i] ? filt_q[i] + FLT_W'(1) : '0;
            // A completed filter takes precedence over a coincident timeout
            if (lock_s_q[i] && (filt_q[i] == FLT_W'(LOCK_FILTER - 1)))
              pst_d[i] = P_READY;
            else if (pcnt_q[i] == CNT_W'(LOCK_TIMEOUT - 1))
              pst_d[i] = P_FAIL;
          end
          P_READY: begin
            if (!lock_s_q[i] || refl_s_q[i]) begin
              pst_d[i]  = P_RESET;
              pcnt_d[i] = '0;
              filt_d[i] = '0;
            end
          end
          default: ;
        endcase
      end
      pd_d[i]    = (pst_q[i] == P_OFF);
      prst_d[i]  = (pst_q[i] == P_OFF) || (pst_q[i] == P_RESET) || (pst_q[i] == P_FAIL);
      prdy_d[i]  = (pst_q[i] == P_READY);
      pfail_d[i] = (pst_q[i] == P_FAIL);
    end
  end

  always_ff @(posedge DRP_CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        pst_q[i]  <= P_OFF;
        pcnt_q[i] <= '0;
        filt_q[i] <= '0;
      end
      pd_q    <= 2'b11;
      prst_q  <= 2'b11;
      prdy_q  <= '0;
      pfail_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        pst_q[i]  <= pst_d[i];
        pcnt_q[i] <= pcnt_d[i];
        filt_q[i] <= filt_d[i];
      end
      pd_q    <= pd_d;
      prst_q  <= prst_d;
      prdy_q  <= prdy_d;
      pfail_q <= pfail_d;
    end
  end

  always_comb begin
    ast_d  = ast_q;
    gnt_d  = gnt_q;
    rr_d   = rr_q;
    tcnt_d = tcnt_q;
    addr_d = addr_q;
    di_d   = di_q;
    we_d   = we_q;
    rdo_d  = rdo_q;
    en_d   = 1'b0;
    rdy_d  = '0;
    err_d  = '0;
    g_sel  = (REQ_EN == 2'b11) ? rr_q : REQ_EN[1];
    case (ast_q)
      A_IDLE: begin
        if (|REQ_EN) begin
          gnt_d  = g_sel;
          rr_d   = ~g_sel;
          addr_d = REQ_ADDR[g_sel];
          di_d   = REQ_DI[g_sel];
          we_d   = REQ_WE[g_sel];
          ast_d  = A_ISSUE;
        end
      end
      A_ISSUE: begin
        en_d   = 1'b1;
        tcnt_d = '0;
        ast_d  = A_WAIT;
      end
      A_WAIT: begin
        if (DRP_RDY) begin
          rdy_d[gnt_q] = 1'b1;
          rdo_d        = DRP_DO;
          ast_d        = A_DONE;
        end else if (tcnt_q == TO_W'(DRP_TIMEOUT - 1)) begin
          rdy_d[gnt_q] = 1'b1;
          err_d[gnt_q] = 1'b1;
          rdo_d        = 16'hDEAD;
          ast_d        = A_DONE;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      // Gives the requester a cycle to drop REQ_EN before re-arbitration
      default: ast_d = A_IDLE;
    endcase
  end

  always_ff @(posedge DRP_CLK or posedge RST) begin
    if (RST) begin
      ast_q  <= A_IDLE;
      gnt_q  <= 1'b0;
      rr_q   <= 1'b0;
      tcnt_q <= '0;
      addr_q <= '0;
      di_q   <= '0;
      we_q   <= 1'b0;
      rdo_q  <= '0;
      en_q   <= 1'b0;
      rdy_q  <= '0;
      err_q  <= '0;
    end else begin
      ast_q  <= ast_d;
      gnt_q  <= gnt_d;
      rr_q   <= rr_d;
      tcnt_q <= tcnt_d;
      addr_q <= addr_d;
      di_q   <= di_d;
      we_q   <= we_d;
      rdo_q  <= rdo_d;
      en_q   <= en_d;
      rdy_q  <= rdy_d;
      err_q  <= err_d;
    end
  end

  assign PLL_PD    = pd_q;
  assign PLL_RESET = prst_q;
  assign PLL_READY = prdy_q;
  assign PLL_FAIL  = pfail_q;
  assign REQ_RDY   = rdy_q;
  assign REQ_ERR   = err_q;
  assign REQ_DO    = rdo_q;
  assign DRP_ADDR  = addr_q;
  assign DRP_DI    = di_q;
  assign DRP_WE    = we_q;
  assign DRP_EN    = en_q;

endmodule
